// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - sequenced async-SRAM controller with byte enables, wait states and read turnaround
module sram_ctrl #(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 1,
    parameter int TURN_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   be,
    output logic                  ready,
    output logic                  rvalid,
    output logic [DATA_W-1:0]     rdata,
    output logic [ADDR_W-1:0]     sram_addr,
    inout  wire  [DATA_W-1:0]     sram_dq,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic [DATA_W/8-1:0]   sram_be_n
);

    localparam int BE_W    = DATA_W / 8;
    localparam int CNT_MAX = (WAIT_CYCLES > TURN_CYCLES) ? WAIT_CYCLES : TURN_CYCLES;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD,
        ST_RD_ACC,
        ST_RD_TURN
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                dq_oe_q, dq_oe_d;
    logic                ce_n_q, ce_n_d;
    logic                oe_n_q, oe_n_d;
    logic                we_n_q, we_n_d;
    logic [BE_W-1:0]     be_n_q, be_n_d;
    logic                rvalid_q, rvalid_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            dq_oe_q  <= 1'b0;
            ce_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
            be_n_q   <= '1;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            dq_oe_q  <= dq_oe_d;
            ce_n_q   <= ce_n_d;
            oe_n_q   <= oe_n_d;
            we_n_q   <= we_n_d;
            be_n_q   <= be_n_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Next-state logic also computes the next value of every pin flop, so strobes
    // only ever change on the edge that enters a state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        dq_oe_d  = dq_oe_q;
        ce_n_d   = ce_n_q;
        oe_n_d   = oe_n_q;
        we_n_d   = we_n_q;
        be_n_d   = be_n_q;
        rvalid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    addr_d = addr;
                    be_n_d = ~be;
                    ce_n_d = 1'b0;
                    cnt_d  = '0;
                    if (we) begin
                        state_d = ST_WR_SETUP;
                        wdata_d = wdata;
                        dq_oe_d = 1'b1;
                    end else begin
                        state_d = ST_RD_ACC;
                        oe_n_d  = 1'b0;
                    end
                end
            end
            ST_WR_SETUP: begin
                state_d = ST_WR_PULSE;
                we_n_d  = 1'b0;
                cnt_d   = '0;
            end
            ST_WR_PULSE: begin
                if (cnt_q == CNT_W'(WAIT_CYCLES)) begin
                    state_d = ST_WR_HOLD;
                    we_n_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WR_HOLD: begin
                state_d = ST_IDLE;
                ce_n_d  = 1'b1;
                be_n_d  = '1;
                dq_oe_d = 1'b0;
            end
            ST_RD_ACC: begin
                if (cnt_q == CNT_W'(WAIT_CYCLES)) begin
                    state_d  = ST_RD_TURN;
                    rdata_d  = sram_dq;
                    rvalid_d = 1'b1;
                    oe_n_d   = 1'b1;
                    ce_n_d   = 1'b1;
                    be_n_d   = '1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RD_TURN: begin
                // SRAM may still be driving DQ as OE rises; hold off the next access.
                if (cnt_q == CNT_W'(TURN_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                dq_oe_d = 1'b0;
                ce_n_d  = 1'b1;
                oe_n_d  = 1'b1;
                we_n_d  = 1'b1;
                be_n_d  = '1;
            end
        endcase
    end

    assign sram_dq   = dq_oe_q ? wdata_q : {DATA_W{1'bz}};
    assign ready     = (state_q == ST_IDLE);
    assign rvalid    = rvalid_q;
    assign rdata     = rdata_q;
    assign sram_addr = addr_q;
    assign sram_ce_n = ce_n_q;
    assign sram_oe_n = oe_n_q;
    assign sram_we_n = we_n_q;
    assign sram_be_n = be_n_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - directed bench for sram_ctrl: instance 0 W=1 T=1, instance 1 W=0 T=1, instance 2 W=2 T=2
module tb_sram_ctrl;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_a       [3];
    logic        we_a        [3];
    logic [19:0] addr_a      [3];
    logic [15:0] wdata_a     [3];
    logic [1:0]  be_a        [3];
    logic        ready_a     [3];
    logic        rvalid_a    [3];
    logic [15:0] rdata_a     [3];
    logic [19:0] sram_addr_a [3];
    logic        ce_n_a      [3];
    logic        oe_n_a      [3];
    logic        we_n_a      [3];
    logic [1:0]  be_n_a      [3];
    logic [15:0] dq_a        [3];
    logic [15:0] mem         [3][256];

    int total = 0;
    int bad = 0;
    int viol = 0;
    int viol_base = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        wire [15:0] dq;
        assign dq = (!ce_n_a[g] && !oe_n_a[g]) ? mem[g][sram_addr_a[g][7:0]] : 16'hzzzz;
        assign dq_a[g] = dq;
        sram_ctrl #(
            .ADDR_W(20), .DATA_W(16),
            .WAIT_CYCLES(g == 0 ? 1 : (g == 1 ? 0 : 2)),
            .TURN_CYCLES(g == 2 ? 2 : 1)
        ) u_dut (
            .clk(clk), .reset_n(reset_n), .req(req_a[g]), .we(we_a[g]), .addr(addr_a[g]),
            .wdata(wdata_a[g]), .be(be_a[g]), .ready(ready_a[g]), .rvalid(rvalid_a[g]),
            .rdata(rdata_a[g]), .sram_addr(sram_addr_a[g]), .sram_dq(dq),
            .sram_ce_n(ce_n_a[g]), .sram_oe_n(oe_n_a[g]), .sram_we_n(we_n_a[g]),
            .sram_be_n(be_n_a[g])
        );
    end

    function automatic bit released(input logic [15:0] v);
        return (v === 16'h0000) || (v === 16'hFFFF) || (v === 16'hzzzz);
    endfunction

    // Behavioural SRAM: lane-masked writes on every clock with WE low.
    always @(posedge clk) begin
        for (int j = 0; j < 3; j++) begin
            if (!ce_n_a[j] && !we_n_a[j]) begin
                if (!be_n_a[j][0]) mem[j][sram_addr_a[j][7:0]][7:0]  <= dq_a[j][7:0];
                if (!be_n_a[j][1]) mem[j][sram_addr_a[j][7:0]][15:8] <= dq_a[j][15:8];
            end
        end
    end

    always @(negedge clk) begin
        for (int j = 0; j < 3; j++) begin
            if (!oe_n_a[j] && !we_n_a[j]) viol++;
            if (ce_n_a[j] && !released(dq_a[j])) viol++;
        end
    end

    task automatic run_op(input int i, input logic w, input logic [19:0] a, input logic [15:0] d,
                          input logic [1:0] b, output int we_lo, output int oe_lo, output int dq_cnt,
                          output int rv_cnt, output int rv_at, output int rdy_at,
                          output logic [15:0] rd, output logic [1:0] ben);
        we_lo = 0; oe_lo = 0; dq_cnt = 0; rv_cnt = 0; rv_at = -1; rdy_at = -1; rd = '0; ben = '1;
        @(negedge clk);
        req_a[i] = 1'b1; we_a[i] = w; addr_a[i] = a; wdata_a[i] = d; be_a[i] = b;
        @(posedge clk); #1;
        req_a[i] = 1'b0;
        for (int k = 0; k < 12 && rdy_at < 0; k++) begin
            @(negedge clk);
            if (k == 0) ben = be_n_a[i];
            if (!we_n_a[i]) we_lo++;
            if (!oe_n_a[i]) oe_lo++;
            if (w && dq_a[i] === d) dq_cnt++;
            if (rvalid_a[i]) begin
                rv_cnt++;
                if (rv_at < 0) begin rv_at = k; rd = rdata_a[i]; end
            end
            if (ready_a[i]) rdy_at = k;
        end
    endtask

    task automatic test_reset();
        for (int j = 0; j < 3; j++) begin
            req_a[j] = 1'b0; we_a[j] = 1'b0; addr_a[j] = '0; wdata_a[j] = '0; be_a[j] = '0;
        end
        req_a[0] = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (ce_n_a[0] !== 1'b1) begin bad++; $display("FAIL rst_ce_n got=%b exp=1", ce_n_a[0]); end
        total++; if (oe_n_a[0] !== 1'b1) begin bad++; $display("FAIL rst_oe_n got=%b exp=1", oe_n_a[0]); end
        total++; if (we_n_a[0] !== 1'b1) begin bad++; $display("FAIL rst_we_n got=%b exp=1", we_n_a[0]); end
        total++; if (be_n_a[0] !== 2'b11) begin bad++; $display("FAIL rst_be_n got=%b exp=11", be_n_a[0]); end
        total++; if (!released(dq_a[0])) begin bad++; $display("FAIL rst_dq got=%h exp=released", dq_a[0]); end
        total++; if (rvalid_a[0] !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%b exp=0", rvalid_a[0]); end
        total++; if (rdata_a[0] !== 16'h0000) begin bad++; $display("FAIL rst_rdata got=%h exp=0000", rdata_a[0]); end
        total++; if (ready_a[0] !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", ready_a[0]); end
        total++; if (sram_addr_a[0] !== 20'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", sram_addr_a[0]); end
        req_a[0] = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        viol_base = viol;
    endtask

    task automatic test_write();
        int we_lo, oe_lo, dq_cnt, rv_cnt, rv_at, rdy_at;
        logic [15:0] rd;
        logic [1:0] ben;
        run_op(0, 1'b1, 20'h00012, 16'hBEEF, 2'b11, we_lo, oe_lo, dq_cnt, rv_cnt, rv_at, rdy_at, rd, ben);
        total++; if (we_lo != 2) begin bad++; $display("FAIL wr_we_low got=%0d exp=2", we_lo); end
        total++; if (dq_cnt != 4) begin bad++; $display("FAIL wr_dq_cycles got=%0d exp=4", dq_cnt); end
        total++; if (rdy_at != 4) begin bad++; $display("FAIL wr_ready_cycle got=%0d exp=4", rdy_at); end
        total++; if (ben !== 2'b00) begin bad++; $display("FAIL wr_be_n got=%b exp=00", ben); end
        total++; if (oe_lo != 0) begin bad++; $display("FAIL wr_oe_low got=%0d exp=0", oe_lo); end
    endtask

    task automatic test_read();
        int we_lo, oe_lo, dq_cnt, rv_cnt, rv_at, rdy_at;
        logic [15:0] rd;
        logic [1:0] ben;
        run_op(0, 1'b0, 20'h00012, 16'h0000, 2'b11, we_lo, oe_lo, dq_cnt, rv_cnt, rv_at, rdy_at, rd, ben);
        total++; if (oe_lo != 2) begin bad++; $display("FAIL rd_oe_low got=%0d exp=2", oe_lo); end
        total++; if (rv_at != 2) begin bad++; $display("FAIL rd_rvalid_cycle got=%0d exp=2", rv_at); end
        total++; if (rv_cnt != 1) begin bad++; $display("FAIL rd_rvalid_count got=%0d exp=1", rv_cnt); end
        total++; if (rd !== 16'hBEEF) begin bad++; $display("FAIL rd_data got=%h exp=BEEF", rd); end
        total++; if (rdy_at != 3) begin bad++; $display("FAIL rd_ready_cycle got=%0d exp=3", rdy_at); end
    endtask

    task automatic test_byte_enable();
        int we_lo, oe_lo, dq_cnt, rv_cnt, rv_at, rdy_at;
        logic [15:0] rd;
        logic [1:0] ben;
        run_op(0, 1'b1, 20'h00012, 16'h1234, 2'b01, we_lo, oe_lo, dq_cnt, rv_cnt, rv_at, rdy_at, rd, ben);
        total++; if (ben !== 2'b10) begin bad++; $display("FAIL be_lane got=%b exp=10", ben); end
        run_op(0, 1'b0, 20'h00012, 16'h0000, 2'b11, we_lo, oe_lo, dq_cnt, rv_cnt, rv_at, rdy_at, rd, ben);
        total++; if (rd !== 16'hBE34) begin bad++; $display("FAIL be_readback got=%h exp=BE34", rd); end
    endtask

    task automatic test_back_to_back(input int i, input int w);
        int rdy_k, oe_k, rv_k;
        logic [15:0] rd;
        logic [15:0] d;
        d = 16'h5A00 + 16'(i);
        rdy_k = -1; oe_k = -1; rv_k = -1; rd = '0;
        @(negedge clk);
        req_a[i] = 1'b1; we_a[i] = 1'b1; addr_a[i] = 20'h00040; wdata_a[i] = d; be_a[i] = 2'b11;
        @(posedge clk); #1;
        we_a[i] = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!oe_n_a[i] && oe_k < 0) oe_k = k;
            if (rvalid_a[i] && rv_k < 0) begin rv_k = k; rd = rdata_a[i]; end
            if (ready_a[i] && rdy_k < 0) begin
                rdy_k = k;
                @(posedge clk); #1;
                req_a[i] = 1'b0;
            end
        end
        req_a[i] = 1'b0;
        total++; if (rdy_k != w + 3) begin bad++; $display("FAIL b2b%0d_ready got=%0d exp=%0d", i, rdy_k, w + 3); end
        total++; if (oe_k != w + 4) begin bad++; $display("FAIL b2b%0d_accept got=%0d exp=%0d", i, oe_k, w + 4); end
        total++; if (rv_k != 2 * w + 5) begin bad++; $display("FAIL b2b%0d_rvalid got=%0d exp=%0d", i, rv_k, 2 * w + 5); end
        total++; if (rd !== d) begin bad++; $display("FAIL b2b%0d_data got=%h exp=%h", i, rd, d); end
        total++; if (viol != viol_base) begin bad++; $display("FAIL b2b%0d_bus_conflict got=%0d exp=%0d", i, viol, viol_base); end
    endtask

    task automatic test_reset_mid_write();
        int rv_cnt;
        rv_cnt = 0;
        @(negedge clk);
        req_a[0] = 1'b1; we_a[0] = 1'b1; addr_a[0] = 20'h00020; wdata_a[0] = 16'hC3A5; be_a[0] = 2'b11;
        @(posedge clk); #1;
        req_a[0] = 1'b0;
        @(posedge clk); #1;
        total++; if (we_n_a[0] !== 1'b0) begin bad++; $display("FAIL abort_in_pulse got=%b exp=0", we_n_a[0]); end
        reset_n = 1'b0;
        #1;
        total++; if (we_n_a[0] !== 1'b1) begin bad++; $display("FAIL abort_we_n got=%b exp=1", we_n_a[0]); end
        total++; if (ce_n_a[0] !== 1'b1) begin bad++; $display("FAIL abort_ce_n got=%b exp=1", ce_n_a[0]); end
        total++; if (!released(dq_a[0])) begin bad++; $display("FAIL abort_dq got=%h exp=released", dq_a[0]); end
        total++; if (rdata_a[0] !== 16'h0000) begin bad++; $display("FAIL abort_rdata got=%h exp=0000", rdata_a[0]); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rvalid_a[0]) rv_cnt++;
        end
        total++; if (rv_cnt != 0) begin bad++; $display("FAIL abort_rvalid got=%0d exp=0", rv_cnt); end
        total++; if (ready_a[0] !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b exp=1", ready_a[0]); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_byte_enable();
        test_back_to_back(1, 0);
        test_back_to_back(2, 2);
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
